// File: rtl/bus_arbiter.sv
// Two-master round-robin wishbone arbiter with one-transaction capture,
// response steering back to the owner, and a BUSY timeout that forces an error ack.
module bus_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int TW      = 8
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   input  logic        m0_we_i,
   input  logic [6:0]  m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,

   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   input  logic        m1_we_i,
   input  logic [6:0]  m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,

   output logic        s_stb_o,
   output logic        s_cyc_o,
   output logic        s_we_o,
   output logic [6:0]  s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,

   output logic [1:0]  grant_o,
   output logic        timeout_o,
   input  logic        clr_timeout_i
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state;
   logic          owner;       // 0 = m0, 1 = m1
   logic          last_grant;  // 0 = m0, 1 = m1
   logic [TW-1:0] cnt;

   logic m0_req, m1_req, pick_m1, owner_cyc, tmo_hit, set_tmo;

   always_comb begin
      m0_req    = m0_cyc_i & m0_stb_i;
      m1_req    = m1_cyc_i & m1_stb_i;
      // m1 wins when alone, or on a tie when m0 was served last
      pick_m1   = m1_req & (~m0_req | ~last_grant);
      owner_cyc = owner ? m1_cyc_i : m0_cyc_i;
      tmo_hit   = (cnt == TW'(TIMEOUT - 1));
      set_tmo   = (state == BUSY) & owner_cyc & ~s_ack_i & tmo_hit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
         s_stb_o    <= 1'b0;
         s_cyc_o    <= 1'b0;
         s_we_o     <= 1'b0;
         s_adr_o    <= '0;
         s_dat_o    <= '0;
         m0_dat_o   <= '0;
         m0_ack_o   <= 1'b0;
         m0_err_o   <= 1'b0;
         m1_dat_o   <= '0;
         m1_ack_o   <= 1'b0;
         m1_err_o   <= 1'b0;
         grant_o    <= 2'b00;
         timeout_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req | m1_req) begin
                  owner      <= pick_m1;
                  last_grant <= pick_m1;
                  s_adr_o    <= pick_m1 ? m1_adr_i : m0_adr_i;
                  s_we_o     <= pick_m1 ? m1_we_i  : m0_we_i;
                  s_dat_o    <= pick_m1 ? m1_dat_i : m0_dat_i;
                  grant_o    <= pick_m1 ? 2'b10 : 2'b01;
                  cnt        <= '0;
                  s_cyc_o    <= 1'b1;
                  s_stb_o    <= 1'b1;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (!owner_cyc) begin
                  // owner abandoned the cycle: release the bus without an ack
                  s_cyc_o <= 1'b0;
                  s_stb_o <= 1'b0;
                  grant_o <= 2'b00;
                  state   <= IDLE;
               end else if (s_ack_i || tmo_hit) begin
                  s_cyc_o <= 1'b0;
                  s_stb_o <= 1'b0;
                  state   <= DONE;
                  if (owner) begin
                     m1_dat_o <= s_ack_i ? s_dat_i : 32'hFFFF_FFFF;
                     m1_ack_o <= 1'b1;
                     m1_err_o <= ~s_ack_i;
                  end else begin
                     m0_dat_o <= s_ack_i ? s_dat_i : 32'hFFFF_FFFF;
                     m0_ack_o <= 1'b1;
                     m0_err_o <= ~s_ack_i;
                  end
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               m0_ack_o <= 1'b0;
               m0_err_o <= 1'b0;
               m1_ack_o <= 1'b0;
               m1_err_o <= 1'b0;
               grant_o  <= 2'b00;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // a fresh timeout outranks a simultaneous clear
         if (set_tmo)
            timeout_o <= 1'b1;
         else if (clr_timeout_i)
            timeout_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: read, round-robin, write capture, timeout,
// abort and asynchronous reset. Inputs driven and outputs sampled on the falling edge.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_stb_i, m0_cyc_i, m0_we_i;
   logic [6:0]  m0_adr_i;
   logic [31:0] m0_dat_i, m0_dat_o;
   logic        m0_ack_o, m0_err_o;
   logic        m1_stb_i, m1_cyc_i, m1_we_i;
   logic [6:0]  m1_adr_i;
   logic [31:0] m1_dat_i, m1_dat_o;
   logic        m1_ack_o, m1_err_o;
   logic        s_stb_o, s_cyc_o, s_we_o;
   logic [6:0]  s_adr_o;
   logic [31:0] s_dat_o, s_dat_i;
   logic        s_ack_i;
   logic [1:0]  grant_o;
   logic        timeout_o, clr_timeout_i;

   int vectors     = 0;
   int miscompares = 0;
   int n;
   logic seen;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT(16), .TW(8)) dut (
      .clk(clk), .rst(rst),
      .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_o(timeout_o), .clr_timeout_i(clr_timeout_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic run_timeout(input string tag);
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s_stb_o) n++;
         if (m0_ack_o) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_len"},  n, 32'd16);
      chk({tag, "_err"},  32'(m0_err_o), 32'd1);
      chk({tag, "_dat"},  m0_dat_o, 32'hFFFF_FFFF);
      chk({tag, "_flag"}, 32'(timeout_o), 32'd1);
   endtask

   initial begin
      rst = 1'b0;
      {m0_stb_i, m0_cyc_i, m0_we_i, m1_stb_i, m1_cyc_i, m1_we_i} = '0;
      m0_adr_i = '0; m1_adr_i = '0; m0_dat_i = '0; m1_dat_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0; clr_timeout_i = 1'b0;
      repeat (2) tick();
      rst = 1'b1;

      // reset state
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_cyc",   32'(s_cyc_o), 32'd0);
      chk("rst_dat0",  m0_dat_o, 32'd0);
      chk("rst_tmo",   32'(timeout_o), 32'd0);

      // single read
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 7'h12;
      tick();
      chk("rd_stb",   32'(s_stb_o), 32'd1);
      chk("rd_grant", 32'(grant_o), 32'd1);
      chk("rd_adr",   32'(s_adr_o), 32'h12);
      chk("rd_we",    32'(s_we_o),  32'd0);
      s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
      tick();
      chk("rd_ack",   32'(m0_ack_o), 32'd1);
      chk("rd_dat",   m0_dat_o, 32'hDEAD_BEEF);
      chk("rd_err",   32'(m0_err_o), 32'd0);
      chk("rd_stb_lo", 32'(s_stb_o), 32'd0);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
      tick();
      chk("rd_ack_lo", 32'(m0_ack_o), 32'd0);
      chk("rd_hold",   m0_dat_o, 32'hDEAD_BEEF);
      chk("rd_idle",   32'(grant_o), 32'd0);

      // simultaneous requests from reset, both held
      rst = 1'b0;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 7'h01;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 7'h02;
      s_ack_i = 1'b1;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr%0d_grant", k), 32'(grant_o), (k % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("rr%0d_adr", k),   32'(s_adr_o), (k % 2 == 0) ? 32'h01 : 32'h02);
         s_dat_i = 32'hA000_0000 + 32'(k);
         tick();
         if (k % 2 == 0) begin
            chk($sformatf("rr%0d_ack0", k), 32'(m0_ack_o), 32'd1);
            chk($sformatf("rr%0d_ack1", k), 32'(m1_ack_o), 32'd0);
            chk($sformatf("rr%0d_dat", k),  m0_dat_o, 32'hA000_0000 + 32'(k));
         end else begin
            chk($sformatf("rr%0d_ack0", k), 32'(m0_ack_o), 32'd0);
            chk($sformatf("rr%0d_ack1", k), 32'(m1_ack_o), 32'd1);
            chk($sformatf("rr%0d_dat", k),  m1_dat_o, 32'hA000_0000 + 32'(k));
         end
         tick();
         chk($sformatf("rr%0d_idle", k), 32'(grant_o), 32'd0);
      end
      {m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i} = '0;
      s_ack_i = 1'b0;
      tick();

      // write capture on m1, data input disturbed after grant
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
      m1_adr_i = 7'h31; m1_dat_i = 32'h0000_0055;
      tick();
      chk("wr_grant", 32'(grant_o), 32'd2);
      m1_dat_i = 32'hFFFF_0000; m1_adr_i = 7'h00;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wr_dat%0d", i), s_dat_o, 32'h0000_0055);
         chk($sformatf("wr_we%0d", i),  32'(s_we_o), 32'd1);
         chk($sformatf("wr_adr%0d", i), 32'(s_adr_o), 32'h31);
         if (i < 2) tick();
      end
      s_ack_i = 1'b1; s_dat_i = 32'h0000_1234;
      tick();
      chk("wr_ack1", 32'(m1_ack_o), 32'd1);
      chk("wr_ack0", 32'(m0_ack_o), 32'd0);
      chk("wr_err",  32'(m1_err_o), 32'd0);
      {m1_cyc_i, m1_stb_i, m1_we_i} = '0;
      s_ack_i = 1'b0;
      tick();
      chk("wr_ack_lo", 32'(m1_ack_o), 32'd0);
      chk("wr_m0hold", m0_dat_o, 32'hA000_0002);

      // timeout, then sticky flag and clear
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 7'h40;
      run_timeout("to1");
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      tick();
      chk("to1_sticky", 32'(timeout_o), 32'd1);
      chk("to1_ack_lo", 32'(m0_ack_o), 32'd0);
      clr_timeout_i = 1'b1;
      tick();
      clr_timeout_i = 1'b0;
      chk("to1_clr", 32'(timeout_o), 32'd0);

      // clear held across a new timeout: set wins, then clear takes effect
      clr_timeout_i = 1'b1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      run_timeout("to2");
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      tick();
      chk("to2_clr", 32'(timeout_o), 32'd0);
      clr_timeout_i = 1'b0;

      // abort in third BUSY cycle
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 7'h22;
      repeat (3) tick();
      chk("ab_busy", 32'(s_cyc_o), 32'd1);
      m0_cyc_i = 1'b0;
      tick();
      chk("ab_cyc",   32'(s_cyc_o), 32'd0);
      chk("ab_stb",   32'(s_stb_o), 32'd0);
      chk("ab_grant", 32'(grant_o), 32'd0);
      chk("ab_ack",   32'(m0_ack_o), 32'd0);
      tick();
      chk("ab_ack2",  32'(m0_ack_o), 32'd0);
      m0_stb_i = 1'b0;

      // asynchronous reset mid-BUSY
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      tick();
      chk("ar_grant", 32'(grant_o), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("ar_cyc",   32'(s_cyc_o), 32'd0);
      chk("ar_stb",   32'(s_stb_o), 32'd0);
      chk("ar_grant0", 32'(grant_o), 32'd0);
      chk("ar_dat",   m0_dat_o, 32'd0);
      chk("ar_ack",   32'(m0_ack_o), 32'd0);
      tick();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      chk("ar_tie", 32'(grant_o), 32'd1);
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single wishbone requester port of the module-dispatch block between two bus masters.
  - m0: the host command interface.
  - m1: the internal scheduler/poller.
- Round-robin arbitration between the two masters.
- Captures one transaction at a time and forwards it downstream.
- Returns the slave response to the owning master.
- Terminates hung transactions with a timeout error response so neither master can stall the bus.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for s_ack_i before forced completion (2..255)
TW, 8, width of timeout counter; must satisfy TIMEOUT <= 2^TW - 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
m0_stb_i, m0_cyc_i, m0_we_i  in  1 each  master 0 wishbone controls
m0_adr_i  in  7  master 0 address
m0_dat_i  in  32  master 0 write data
m0_dat_o  out  32  master 0 read data
m0_ack_o  out  1  master 0 ack
m0_err_o  out  1  master 0 timeout error, valid with m0_ack_o
m1_* (stb_i, cyc_i, we_i, adr_i[6:0], dat_i[31:0], dat_o[31:0], ack_o, err_o)  as m0
s_stb_o, s_cyc_o, s_we_o  out  1 each  downstream wishbone controls
s_adr_o  out  7  downstream address
s_dat_o  out  32  downstream write data
s_dat_i  in  32  downstream read data
s_ack_i  in  1  downstream ack
grant_o  out  2  one-hot current owner, 00 when idle
timeout_o  out  1  sticky flag, set on any timeout
clr_timeout_i  in  1  clears timeout_o

Behaviour:
- Reset (rst=0, async):
  - State IDLE; all outputs 0, including dat_o, grant_o and timeout_o.
  - last_grant = m1, so m0 wins the first tie.
  - Reset mid-transaction abandons it: no ack is issued, s_cyc_o drops immediately.
- Request: mN_req = mN_cyc_i & mN_stb_i.
- IDLE:
  - If exactly one request is present, grant it.
  - If both are present, grant the master not equal to last_grant.
  - On grant, register s_adr_o/s_we_o/s_dat_o from the winner, set grant_o, set last_grant to the winner, clear the counter, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - s_cyc_o = s_stb_o = 1 (registered, asserted the cycle after the request is sampled).
  - s_ack_i=1: register mN_dat_o=s_dat_i, mN_ack_o=1, mN_err_o=0; go to DONE.
  - No ack and counter == TIMEOUT-1: mN_dat_o=32'hFFFFFFFF, mN_ack_o=1, mN_err_o=1, timeout_o=1; go to DONE. BUSY therefore lasts exactly TIMEOUT cycles.
  - Otherwise: increment the counter.
  - Granted master drops cyc_i while in BUSY (abort): drop s_cyc_o/s_stb_o next cycle, go to IDLE, no ack, last_grant still updated.
- DONE (1 cycle):
  - s_cyc_o = s_stb_o = 0; mN_ack_o held high for this single cycle only; go to IDLE.
  - The other master's request is sampled in the IDLE cycle that follows.
- Data and ack rules:
  - mN_dat_o holds its last value until the next completion for that master.
  - The ungranted master never sees ack or err.
  - s_ack_i outside BUSY is ignored.
  - s_adr_o/s_dat_o/s_we_o are stable for the whole BUSY state.
- Latency: request sampled in IDLE at cycle T, downstream strobe at T+1, immediate slave ack at T+1, master ack at T+2. Minimum transaction period per master is 3 cycles.
- timeout_o:
  - Set takes priority over clr_timeout_i in the same cycle.
  - Otherwise cleared by clr_timeout_i=1.
- Counter saturates and never wraps.

Test Plan:
- Single read: m0 read at adr 7'h12, slave acks in first BUSY cycle with 32'hDEADBEEF. Required:
  - s_stb_o high for 1 cycle.
  - m0_ack_o at T+2 with m0_dat_o=32'hDEADBEEF, m0_err_o=0.
  - grant_o=01 during BUSY.
- Simultaneous requests: m0 and m1 request together from reset. Required:
  - m0 served first.
  - m1 granted in the IDLE cycle after DONE.
  - With both requests held continuously, grants alternate 01,10,01,10 over 4 transactions.
- Write capture: m1 writes 32'h00000055 to adr 7'h31, with m1_dat_i changed on the cycle after grant. Required:
  - s_dat_o=32'h55 and s_we_o=1 throughout BUSY.
  - m1_ack_o 1 cycle, m0_ack_o stays 0.
- Timeout: TIMEOUT=16, slave never acks. Required:
  - s_stb_o high exactly 16 cycles.
  - m0_ack_o=1, m0_err_o=1, m0_dat_o=32'hFFFFFFFF.
  - timeout_o=1 until clr_timeout_i pulsed; clr in the same cycle as a new timeout leaves it at 1.
- Abort and reset: m0 drops cyc in the 3rd BUSY cycle, giving IDLE with no ack. Separately, rst=0 asserted mid-BUSY. Required:
  - All outputs 0 asynchronously.
  - After release, m0 wins a tie.
